// File: rtl/wb_trace_char_writer_pkg.sv
// Shared types and helpers for the writeback trace character writer.
// Holds the event record, FSM state type, ASCII constants and the
// hex / decimal digit conversion functions used to render a trace line.
package wb_trace_pkg;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_R     = 8'h72;
   localparam logic [7:0] ASCII_EQ    = 8'h3D;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_A     = 8'h41;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // One register-file write as seen by the writeback stage.
   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } wb_event_t;

   // Nibble to uppercase ASCII hex digit.
   function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
      logic [7:0] w;
      w = {4'h0, n};
      if (n < 4'd10) begin
         return ASCII_ZERO + w;
      end
      return ASCII_A + (w - 8'd10);
   endfunction

   // Register number (0..31) to {tens, units} BCD digits.
   function automatic logic [7:0] dec_digits(input logic [4:0] n);
      logic [3:0] t;
      if (n >= 5'd30)      t = 4'd3;
      else if (n >= 5'd20) t = 4'd2;
      else if (n >= 5'd10) t = 4'd1;
      else                 t = 4'd0;
      return {t, 4'(n - 5'(t) * 5'd10)};
   endfunction

endpackage

// File: rtl/wb_trace_char_writer_fifo.sv
// trace_fifo: synchronous FIFO for trace events, combinational head read.
// Latency: a push is visible on o_dat/o_empty the cycle after the push edge.
// Backpressure: none internally; caller must not push when full unless popping.
// Ports: clk/reset (sync, active-high); i_push/i_dat write side; i_pop
//        consumes head o_dat; o_full/o_empty/o_count report occupancy.
module trace_fifo #(
   parameter int W     = 69,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_dat,
   output logic [W-1:0]             o_dat,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // Push while full overwrites the head slot; the head is read
   // combinationally this cycle, so the pop still gets the old entry.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
   end

   assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];
   assign o_count = r_wr_ptr - r_rd_ptr;
   assign o_empty = (o_count == '0);
   assign o_full  = (o_count == FULL_CNT);

endmodule

// File: rtl/wb_trace_char_writer.sv
// wb_trace_char_writer: renders each register-file write as one text line in the VGA char buffer.
// Latency: 2 cycles from wb_valid to first char_we; a line is COLS consecutive char_we cycles.
// Backpressure: none upstream (WB never stalls); events beyond the FIFO are dropped and counted.
// Ports: clk/reset (sync, active-high); wb_valid/wb_pc/wb_wnum/wb_wdata event in;
//        char_we/char_addr/char_data buffer write out; busy; drop_cnt (saturating).
// Build option: define WB_TRACE_SKIP_R0_EN to ignore writes to r0 entirely.
module wb_trace_char_writer
   import wb_trace_pkg::*;
#(
   parameter int COLS       = 80,
   parameter int ROWS       = 30,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_valid,
   input  logic [31:0]       wb_pc,
   input  logic [4:0]        wb_wnum,
   input  logic [31:0]       wb_wdata,
   output logic              char_we,
   output logic [ADDR_W-1:0] char_addr,
   output logic [7:0]        char_data,
   output logic              busy,
   output logic [15:0]       drop_cnt
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
   localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

   wb_event_t         w_in_ev;
   wb_event_t         w_head_ev;
   wb_event_t         r_line;
   logic              w_full;
   logic              w_empty;
   logic [CNT_W-1:0]  w_count;
   logic [CNT_W-1:0]  w_count_nxt;
   logic              w_ev_vld;
   logic              w_push;
   logic              w_pop;
   logic              w_drop;
   logic              w_line_end;
   logic              w_emit_nxt;
   logic [ADDR_W-1:0] w_next_base;

   state_t            r_state;
   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;
   logic [ADDR_W-1:0] r_row_base;
   logic              r_char_we;
   logic [ADDR_W-1:0] r_char_addr;
   logic [7:0]        r_char_data;
   logic              r_busy;
   logic [15:0]       r_drop_cnt;

   // ASCII for column col of the line "PPPPPPPP rNN=DDDDDDDD", spaces after.
   function automatic logic [7:0] char_at(input wb_event_t ev, input int col);
      logic [7:0] dd;
      dd = dec_digits(ev.wnum);
      if (col < 8)        return hex_to_ascii(4'(ev.pc >> (4 * (7 - col))));
      else if (col == 9)  return ASCII_R;
      else if (col == 10) return ASCII_ZERO + {4'h0, dd[7:4]};
      else if (col == 11) return ASCII_ZERO + {4'h0, dd[3:0]};
      else if (col == 12) return ASCII_EQ;
      else if (col >= 13 && col <= 20)
         return hex_to_ascii(4'(ev.wdata >> (4 * (20 - col))));
      return ASCII_SPACE;
   endfunction

   assign w_in_ev = {wb_pc, wb_wnum, wb_wdata};

`ifdef WB_TRACE_SKIP_R0_EN
   assign w_ev_vld = wb_valid && (wb_wnum != 5'd0);
`else
   assign w_ev_vld = wb_valid;
`endif

   assign w_line_end = (r_state == EMIT) && (r_col == LAST_COL);
   // Pop in IDLE or on the last column so consecutive lines have no bubble.
   assign w_pop      = !w_empty && ((r_state == IDLE) || w_line_end);
   assign w_push     = w_ev_vld && (!w_full || w_pop);
   assign w_drop     = w_ev_vld && w_full && !w_pop;

   assign w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
   assign w_emit_nxt  = (r_state == IDLE) ? !w_empty : (!w_line_end || !w_empty);
   assign w_next_base = (r_row == LAST_ROW) ? '0 : r_row_base + COLS_A;

   trace_fifo #(
      .W     ($bits(wb_event_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_dat   (w_in_ev),
      .o_dat   (w_head_ev),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // r_col is the column currently presented on char_addr/char_data, so the
   // char for the next column is computed one cycle ahead and registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_col       <= '0;
         r_row       <= '0;
         r_row_base  <= '0;
         r_line      <= '0;
         r_char_we   <= 1'b0;
         r_char_addr <= '0;
         r_char_data <= ASCII_SPACE;
         r_busy      <= 1'b0;
         r_drop_cnt  <= '0;
      end else begin
         r_busy <= w_emit_nxt || (w_count_nxt != '0);
         if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end

         case (r_state)
            IDLE: begin
               r_char_we <= 1'b0;
               if (!w_empty) begin
                  r_state     <= EMIT;
                  r_line      <= w_head_ev;
                  r_col       <= '0;
                  r_char_we   <= 1'b1;
                  r_char_addr <= r_row_base;
                  r_char_data <= char_at(w_head_ev, 0);
               end
            end
            EMIT: begin
               if (r_col != LAST_COL) begin
                  r_col       <= r_col + COL_W'(1);
                  r_char_we   <= 1'b1;
                  r_char_addr <= r_char_addr + ADDR_W'(1);
                  r_char_data <= char_at(r_line, int'(r_col) + 1);
               end else begin
                  r_row      <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
                  r_row_base <= w_next_base;
                  if (!w_empty) begin
                     r_line      <= w_head_ev;
                     r_col       <= '0;
                     r_char_we   <= 1'b1;
                     r_char_addr <= w_next_base;
                     r_char_data <= char_at(w_head_ev, 0);
                  end else begin
                     r_state   <= IDLE;
                     r_char_we <= 1'b0;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign char_we   = r_char_we;
   assign char_addr = r_char_addr;
   assign char_data = r_char_data;
   assign busy      = r_busy;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace_char_writer.sv
// Self-checking bench for wb_trace_char_writer: scoreboard of expected characters.
module tb_wb_trace_char_writer;

   localparam int COLS   = 80;
   localparam int ROWS   = 30;
   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic              wb_valid;
   logic [31:0]       wb_pc;
   logic [4:0]        wb_wnum;
   logic [31:0]       wb_wdata;
   logic              char_we;
   logic [ADDR_W-1:0] char_addr;
   logic [7:0]        char_data;
   logic              busy;
   logic [15:0]       drop_cnt;

   always #5 clk = ~clk;

   wb_trace_char_writer #(
      .COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(4), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
      .wb_wnum(wb_wnum), .wb_wdata(wb_wdata), .char_we(char_we),
      .char_addr(char_addr), .char_data(char_data), .busy(busy),
      .drop_cnt(drop_cnt)
   );

   typedef struct { int cyc; int addr; int data; } obs_t;
   typedef struct { int addr; int data; } exp_t;

   obs_t obs_q[$];
   exp_t exp_q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_row  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (char_we === 1'b1)
         obs_q.push_back('{cyc: cyc, addr: int'(char_addr), data: int'(char_data)});

   // Reference model: push the COLS expected characters of one line.
   task automatic push_line(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
      string      hx;
      logic [7:0] ln [COLS];
      hx = "0123456789ABCDEF";
      for (int c = 0; c < COLS; c++) ln[c] = 8'h20;
      for (int i = 0; i < 8; i++) begin
         ln[i]      = hx[int'((pc >> (28 - 4 * i)) & 32'hF)];
         ln[13 + i] = hx[int'((wd >> (28 - 4 * i)) & 32'hF)];
      end
      ln[9]  = 8'h72;
      ln[10] = 8'h30 + 8'(wn / 10);
      ln[11] = 8'h30 + 8'(wn % 10);
      ln[12] = 8'h3D;
      for (int c = 0; c < COLS; c++)
         exp_q.push_back('{addr: exp_row * COLS + c, data: int'(ln[c])});
      exp_row = (exp_row + 1) % ROWS;
   endtask

   task automatic send_event(input logic [31:0] pc, input logic [4:0] wn,
                             input logic [31:0] wd, output int drv_cyc);
      @(negedge clk);
      wb_valid = 1'b1; wb_pc = pc; wb_wnum = wn; wb_wdata = wd;
      drv_cyc = cyc;
      @(negedge clk);
      wb_valid = 1'b0;
   endtask

   task automatic wait_obs(input int n, input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (obs_q.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_idle(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (busy === 1'b0 && char_we === 1'b0) break;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic apply_reset();
      wb_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      obs_q.delete();
      exp_q.delete();
      exp_row = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1; wb_valid = 1'b0; wb_pc = '0; wb_wnum = '0; wb_wdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (char_we !== 1'b0) begin n_fail++; $display("FAIL reset_char_we: got %b want 0", char_we); end
      n_checks++; if (char_addr !== '0) begin n_fail++; $display("FAIL reset_char_addr: got %0d want 0", char_addr); end
      n_checks++; if (char_data !== 8'h20) begin n_fail++; $display("FAIL reset_char_data: got %02h want 20", char_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
      obs_q.delete();
      exp_row = 0;
   endtask

   task automatic test_single();
      int         drv;
      int         first;
      bit         ok;
      exp_t       e;
      obs_t       o;
      logic [7:0] got [COLS];
      string      s;
      s = "BFC00000 r09=0000000D";
      for (int c = 0; c < COLS; c++) got[c] = 8'h00;
      push_line(32'hBFC0_0000, 5'd9, 32'h0000_000D);
      send_event(32'hBFC0_0000, 5'd9, 32'h0000_000D, drv);
      wait_obs(COLS, 400, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d chars want %0d", obs_q.size(), COLS); end
      first = (obs_q.size() > 0) ? obs_q[0].cyc - drv : -1;
      n_checks++; if (first !== 2) begin n_fail++; $display("FAIL single_latency: got %0d cycles want 2", first); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         if (o.addr >= 0 && o.addr < COLS) got[o.addr] = 8'(o.data);
         n_checks++;
         if (o.addr !== e.addr || o.data !== e.data) begin
            n_fail++; $display("FAIL single_char: got addr=%0d data=%02h want addr=%0d data=%02h", o.addr, o.data, e.addr, e.data);
         end
      end
      exp_q.delete();
      for (int c = 0; c < 21; c++) begin
         n_checks++; if (got[c] !== s[c]) begin n_fail++; $display("FAIL single_text col %0d: got %02h want %02h", c, got[c], s[c]); end
      end
      wait_idle(200);
      n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL single_extra: got %0d extra chars want 0", obs_q.size()); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b want 0", busy); end
      obs_q.delete();
   endtask

   task automatic test_hex_high();
      int         drv;
      int         base;
      bit         ok;
      exp_t       e;
      obs_t       o;
      logic [7:0] got [COLS];
      logic [7:0] want [11];
      want = '{8'h33, 8'h31, 8'h3D, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h30, 8'h31};
      for (int c = 0; c < COLS; c++) got[c] = 8'h00;
      base = exp_row * COLS;
      push_line(32'h0040_12F8, 5'd31, 32'hABCD_EF01);
      send_event(32'h0040_12F8, 5'd31, 32'hABCD_EF01, drv);
      wait_obs(COLS, 400, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL hex_timeout: got %0d chars want %0d", obs_q.size(), COLS); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         if (o.addr >= base && o.addr < base + COLS) got[o.addr - base] = 8'(o.data);
         n_checks++;
         if (o.addr !== e.addr || o.data !== e.data) begin
            n_fail++; $display("FAIL hex_char: got addr=%0d data=%02h want addr=%0d data=%02h", o.addr, o.data, e.addr, e.data);
         end
      end
      exp_q.delete();
      for (int c = 0; c < 11; c++) begin
         n_checks++; if (got[10 + c] !== want[c]) begin n_fail++; $display("FAIL hex_text col %0d: got %02h want %02h", 10 + c, got[10 + c], want[c]); end
      end
      wait_idle(200);
      obs_q.delete();
   endtask

   task automatic test_r0();
      int          drv;
      bit          ok;
      exp_t        e;
      obs_t        o;
      logic [15:0] drop_before;
      drop_before = drop_cnt;
`ifdef WB_TRACE_SKIP_R0_EN
      send_event(32'h0000_1000, 5'd0, 32'h1234_5678, drv);
      ok = 1'b1;
      repeat (100) @(negedge clk);
      n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL r0_skip_chars: got %0d chars want 0", obs_q.size()); end
      n_checks++; if (drop_cnt !== drop_before) begin n_fail++; $display("FAIL r0_skip_drop: got %0d want %0d", drop_cnt, drop_before); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL r0_skip_busy: got %b want 0", busy); end
`else
      push_line(32'h0000_1000, 5'd0, 32'h1234_5678);
      send_event(32'h0000_1000, 5'd0, 32'h1234_5678, drv);
      wait_obs(COLS, 400, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL r0_timeout: got %0d chars want %0d (drv cyc %0d)", obs_q.size(), COLS, drv); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o.addr !== e.addr || o.data !== e.data) begin
            n_fail++; $display("FAIL r0_char: got addr=%0d data=%02h want addr=%0d data=%02h", o.addr, o.data, e.addr, e.data);
         end
      end
      exp_q.delete();
      wait_idle(200);
      n_checks++; if (drop_cnt !== drop_before) begin n_fail++; $display("FAIL r0_drop: got %0d want %0d", drop_cnt, drop_before); end
`endif
      obs_q.delete();
   endtask

   task automatic test_burst();
      bit          ok;
      bit          gap_ok;
      int          first;
      exp_t        e;
      obs_t        o;
      logic [31:0] pc;
      logic [31:0] wd;
      apply_reset();
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         pc = 32'h8000_0000 + 32'(i * 4);
         wd = $urandom;
         wb_valid = 1'b1; wb_pc = pc; wb_wnum = 5'(i + 1); wb_wdata = wd;
         if (i < 5) push_line(pc, 5'(i + 1), wd);
         @(negedge clk);
      end
      wb_valid = 1'b0;
      wait_obs(5 * COLS, 1000, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL burst_timeout: got %0d chars want %0d", obs_q.size(), 5 * COLS); end
      gap_ok = 1'b1;
      first = (obs_q.size() > 0) ? obs_q[0].cyc : 0;
      for (int i = 0; i < obs_q.size(); i++)
         if (obs_q[i].cyc != first + i) gap_ok = 1'b0;
      n_checks++; if (gap_ok !== 1'b1) begin n_fail++; $display("FAIL burst_gapless: got gaps=%b want 0", !gap_ok); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o.addr !== e.addr || o.data !== e.data) begin
            n_fail++; $display("FAIL burst_char: got addr=%0d data=%02h want addr=%0d data=%02h", o.addr, o.data, e.addr, e.data);
         end
      end
      exp_q.delete();
      wait_idle(300);
      n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL burst_extra: got %0d extra chars want 0", obs_q.size()); end
      n_checks++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL burst_drop_cnt: got %0d want 1", drop_cnt); end
      obs_q.delete();
   endtask

   task automatic test_reset_mid();
      bit   ok;
      bit   found;
      int   base;
      int   drv;
      exp_t e;
      obs_t o;
      base = exp_row * COLS;
      push_line(32'h0000_0100, 5'd4, 32'h0000_0044);
      while (exp_q.size() > 41) void'(exp_q.pop_back());
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         wb_valid = 1'b1; wb_pc = 32'h0000_0100 + 32'(i * 4); wb_wnum = 5'(4 + i); wb_wdata = 32'h44 + 32'(i);
         @(negedge clk);
      end
      wb_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (char_we === 1'b1 && int'(char_addr) == base + 40) begin found = 1'b1; break; end
         @(negedge clk);
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL mid_col40_seen: got 0 want 1"); end
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (char_we !== 1'b0) begin n_fail++; $display("FAIL mid_char_we: got %b want 0", char_we); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
      n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_drop_cnt: got %0d want 0", drop_cnt); end
      reset = 1'b0;
      n_checks++; if (obs_q.size() !== 41) begin n_fail++; $display("FAIL mid_partial_len: got %0d chars want 41", obs_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o.addr !== e.addr || o.data !== e.data) begin
            n_fail++; $display("FAIL mid_partial_char: got addr=%0d data=%02h want addr=%0d data=%02h", o.addr, o.data, e.addr, e.data);
         end
      end
      exp_q.delete();
      obs_q.delete();
      exp_row = 0;
      push_line(32'h0000_0200, 5'd17, 32'hFEED_0001);
      send_event(32'h0000_0200, 5'd17, 32'hFEED_0001, drv);
      wait_obs(COLS, 400, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_after_timeout: got %0d chars want %0d", obs_q.size(), COLS); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o.addr !== e.addr || o.data !== e.data) begin
            n_fail++; $display("FAIL mid_after_char: got addr=%0d data=%02h want addr=%0d data=%02h", o.addr, o.data, e.addr, e.data);
         end
      end
      exp_q.delete();
      wait_idle(300);
      n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL mid_flushed: got %0d extra chars want 0", obs_q.size()); end
      n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_drop_after: got %0d want 0", drop_cnt); end
      obs_q.delete();
   endtask

   task automatic test_row_wrap();
      bit          ok;
      int          drv;
      exp_t        e;
      obs_t        o;
      logic [31:0] wd;
      apply_reset();
      for (int k = 0; k < 31; k++) begin
         wd = $urandom;
         push_line(32'h0010_0000 + 32'(k * 16), 5'(k), wd);
         send_event(32'h0010_0000 + 32'(k * 16), 5'(k), wd, drv);
         wait_obs(COLS, 400, ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout ev %0d: got %0d chars want %0d", k, obs_q.size(), COLS); end
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.addr !== e.addr || o.data !== e.data) begin
               n_fail++; $display("FAIL wrap_char ev %0d: got addr=%0d data=%02h want addr=%0d data=%02h", k, o.addr, o.data, e.addr, e.data);
            end
         end
         exp_q.delete();
         wait_idle(200);
         obs_q.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_hex_high();
      test_r0();
      test_burst();
      test_reset_mid();
      test_row_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
